// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD sequencer.
package sad_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S_TMPL = 2'd1,
    S_FRM  = 2'd2,
    DONE   = 2'd3
  } sad_state_e;

  localparam int ADDR_STEP = 4;   // bytes per pixel word
  localparam int SAD_W     = 32;  // pixel and accumulator width
  localparam int DIM_W     = 5;   // width of BlockW / BlockH fields

endpackage

// File: rtl/sad_absdiff.sv
// Combinational unsigned absolute difference |a - b|.
module sad_absdiff
  import sad_pkg::*;
(
  input  logic [SAD_W-1:0] i_a,
  input  logic [SAD_W-1:0] i_b,
  output logic [SAD_W-1:0] o_diff
);

  // Subtract the smaller operand from the larger so the result is exact.
  always_comb begin
    o_diff = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
  end

endmodule

// File: rtl/sad_engine.sv
// SAD sequencer: alternates template / frame reads from a zero-latency
// memory and accumulates |template - frame| over a W x H block.
module sad_engine
  import sad_pkg::*;
#(
  parameter int MAX_DIM = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] TemplateBase,
  input  logic [ADDR_W-1:0] FrameBase,
  input  logic [15:0]       FrameStride,
  input  logic [DIM_W-1:0]  BlockW,
  input  logic [DIM_W-1:0]  BlockH,
  output logic [ADDR_W-1:0] Address,
  output logic              MemRead,
  input  logic [SAD_W-1:0]  ReadData,
  output logic              Busy,
  output logic              Done,
  output logic [SAD_W-1:0]  SadOut
);

  localparam int StepSh = $clog2(ADDR_STEP);

  if (MAX_DIM >= (1 << DIM_W)) begin : g_dim_check
    $error("MAX_DIM does not fit the dimension field width");
  end

  sad_state_e        r_state, w_next;
  logic [ADDR_W-1:0] r_trow, r_frow;    // current row bases
  logic [ADDR_W-1:0] r_tstep, r_fstep;  // byte step from one row to the next
  logic [DIM_W-1:0]  r_w, r_h;
  logic [DIM_W-1:0]  r_r, r_c;
  logic [SAD_W-1:0]  r_treg;
  logic [SAD_W-1:0]  r_sad;

  logic [ADDR_W-1:0] w_coloff;
  logic [SAD_W-1:0]  w_absdiff;
  logic              w_last_c, w_last_r;

  assign w_coloff = ADDR_W'(r_c) << StepSh;
  assign w_last_c = (r_c == (r_w - DIM_W'(1)));
  assign w_last_r = (r_r == (r_h - DIM_W'(1)));
  assign SadOut   = r_sad;

  sad_absdiff u_absdiff (
    .i_a    (r_treg),
    .i_b    (ReadData),
    .o_diff (w_absdiff)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and state-decoded memory/status outputs.
  always_comb begin
    w_next  = r_state;
    Address = '0;
    MemRead = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start) begin
          w_next = ((BlockW == '0) || (BlockH == '0)) ? DONE : S_TMPL;
        end
      end
      S_TMPL: begin
        Address = r_trow + w_coloff;
        MemRead = 1'b1;
        Busy    = 1'b1;
        w_next  = S_FRM;
      end
      S_FRM: begin
        Address = r_frow + w_coloff;
        MemRead = 1'b1;
        Busy    = 1'b1;
        w_next  = (w_last_c && w_last_r) ? DONE : S_TMPL;
      end
      DONE: begin
        Done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Config latch, pixel counters, row-base walk and SAD accumulation.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_trow  <= '0;
      r_frow  <= '0;
      r_tstep <= '0;
      r_fstep <= '0;
      r_w     <= '0;
      r_h     <= '0;
      r_r     <= '0;
      r_c     <= '0;
      r_treg  <= '0;
      r_sad   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_trow  <= TemplateBase;
            r_frow  <= FrameBase;
            r_tstep <= ADDR_W'(BlockW) << StepSh;
            r_fstep <= ADDR_W'(FrameStride) << StepSh;
            r_w     <= BlockW;
            r_h     <= BlockH;
            r_r     <= '0;
            r_c     <= '0;
            r_sad   <= '0;
          end
        end
        S_TMPL: r_treg <= ReadData;
        S_FRM: begin
          r_sad <= r_sad + w_absdiff;
          if (w_last_c) begin
            r_c    <= '0;
            r_r    <= r_r + DIM_W'(1);
            r_trow <= r_trow + r_tstep;
            r_frow <= r_frow + r_fstep;
          end else begin
            r_c <= r_c + DIM_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_engine.sv
// Scoreboard bench for sad_engine: a reference model fills expected address
// and SAD queues; a monitor on the falling edge pops and compares.
module tb_sad_engine;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [31:0] TemplateBase, FrameBase;
  logic [15:0] FrameStride;
  logic [4:0]  BlockW, BlockH;
  logic [31:0] Address;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Busy, Done;
  logic [31:0] SadOut;

  logic [31:0] mem [0:4095];
  logic [31:0] exp_q [$];
  logic [31:0] addr_q [$];
  logic [31:0] last_sad;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 Clk = ~Clk;

  assign ReadData = mem[Address[13:2]];

  sad_engine #(.MAX_DIM(16), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
    .TemplateBase(TemplateBase), .FrameBase(FrameBase),
    .FrameStride(FrameStride), .BlockW(BlockW), .BlockH(BlockH),
    .Address(Address), .MemRead(MemRead), .ReadData(ReadData),
    .Busy(Busy), .Done(Done), .SadOut(SadOut)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event with nothing expected at %0t", name, $time);
  endtask

  // Monitor: every read address and every Done is matched against the queues.
  always @(negedge Clk) begin
    if (Rst_n === 1'b1) begin
      if (MemRead) begin
        if (addr_q.size() == 0) flag("unexpected_read");
        else check("address", Address, addr_q.pop_front());
      end
      if (Done) begin
        if (exp_q.size() == 0) flag("unexpected_done");
        else check("sadout", SadOut, exp_q.pop_front());
      end
    end
  end

  // Reference model: walk the block pixel by pixel from the definition.
  task automatic model(input logic [31:0] tb, input logic [31:0] fb,
                       input logic [15:0] stride, input int w, input int h);
    logic [31:0] ta, fa, t, f, sad;
    sad = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        ta = tb + 32'(4 * (r * w + c));
        fa = fb + 32'(4 * (r * int'(stride) + c));
        addr_q.push_back(ta);
        addr_q.push_back(fa);
        t = mem[ta[13:2]];
        f = mem[fa[13:2]];
        sad = sad + ((t >= f) ? (t - f) : (f - t));
      end
    end
    exp_q.push_back(sad);
    last_sad = sad;
  endtask

  // mode 0: plain run; 1: Start re-pulsed and config scrambled mid-run;
  // 2: reset dropped during S_FRM.
  task automatic run(input logic [31:0] tb, input logic [31:0] fb,
                     input logic [15:0] stride, input int w, input int h, input int mode);
    int cnt;
    @(posedge Clk); #1;
    TemplateBase = tb; FrameBase = fb; FrameStride = stride;
    BlockW = 5'(w); BlockH = 5'(h);
    Start = 1'b1;
    model(tb, fb, stride, w, h);
    @(posedge Clk); #1;
    Start = 1'b0;
    cnt = 0;
    @(negedge Clk);
    while (!Done && cnt < 2000) begin
      if (mode == 1 && cnt == 2) begin
        Start = 1'b1;
        TemplateBase = $urandom; FrameBase = $urandom;
        FrameStride = 16'($urandom); BlockW = 5'($urandom); BlockH = 5'($urandom);
      end
      if (mode == 1 && cnt == 5) Start = 1'b0;
      if (mode == 2 && cnt == 5) begin
        #2 Rst_n = 1'b0;
        #1;
        check("rst_address", Address, 32'd0);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_sadout", SadOut, 32'd0);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge Clk);
        #2 Rst_n = 1'b1;
        repeat (4) @(negedge Clk);
        return;
      end
      @(negedge Clk);
      cnt++;
    end
    Start = 1'b0;
    check("done_latency", 32'(cnt), 32'(2 * w * h));
    @(negedge Clk);
    check("done_pulse", 32'(Done), 32'd0);
    check("sad_hold", SadOut, last_sad);
  endtask

  initial begin
    Rst_n = 1'b0; Start = 1'b0;
    TemplateBase = '0; FrameBase = '0; FrameStride = '0; BlockW = '0; BlockH = '0;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    repeat (3) @(posedge Clk);
    #1;
    check("reset_address", Address, 32'd0);
    check("reset_memread", 32'(MemRead), 32'd0);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_sadout", SadOut, 32'd0);
    #1 Rst_n = 1'b1;

    // 1x1: template 10, frame 3
    mem[32'h40 >> 2] = 32'd10;
    mem[32'h80 >> 2] = 32'd3;
    run(32'h40, 32'h80, 16'd1, 1, 1, 0);
    check("sad_1x1", SadOut, 32'd7);

    // 2x2 with stride 8
    mem[32'h100 >> 2] = 1; mem[32'h104 >> 2] = 2; mem[32'h108 >> 2] = 3; mem[32'h10C >> 2] = 4;
    mem[32'h200 >> 2] = 4; mem[32'h204 >> 2] = 2; mem[32'h220 >> 2] = 0; mem[32'h224 >> 2] = 9;
    run(32'h100, 32'h200, 16'd8, 2, 2, 0);
    check("sad_2x2", SadOut, 32'd11);

    // Extremes: 1 row of 2 pixels, each difference 0xFFFFFFFF
    mem[32'h300 >> 2] = 32'h0; mem[32'h304 >> 2] = 32'hFFFF_FFFF;
    mem[32'h400 >> 2] = 32'hFFFF_FFFF; mem[32'h404 >> 2] = 32'h0;
    run(32'h300, 32'h400, 16'd2, 2, 1, 0);
    check("sad_extreme", SadOut, 32'hFFFF_FFFE);

    // Zero dimensions: no reads, Done next cycle, SAD cleared
    run(32'h500, 32'h600, 16'd4, 0, 3, 0);
    check("sad_zero_w", SadOut, 32'd0);
    run(32'h500, 32'h600, 16'd4, 3, 0, 0);

    // Address wrap across 2^32
    run(32'hFFFF_FFF8, 32'hFFFF_FFF0, 16'd3, 2, 2, 0);

    // Start re-pulsed with scrambled config while busy
    run(32'h700, 32'h900, 16'd5, 3, 3, 1);

    // Reset mid-run, then a clean run
    run(32'h800, 32'hA00, 16'd6, 4, 4, 2);
    run(32'h800, 32'hA00, 16'd6, 4, 4, 0);

    // Randomized runs, including a full 16x16 block
    for (int k = 0; k < 20; k++) begin
      int w, h;
      w = (k == 0) ? 16 : int'($urandom_range(1, 6));
      h = (k == 0) ? 16 : int'($urandom_range(1, 6));
      run({18'd0, 12'($urandom_range(0, 1023)), 2'b00},
          32'h1000 + {18'd0, 12'($urandom_range(0, 1023)), 2'b00},
          16'($urandom_range(0, 20)), w, h, 0);
    end

    repeat (4) @(negedge Clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("addr_q_drained", 32'(addr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
